rv64_ise_issue: RTL and testbench

- Issue/writeback pipeline for the Ascon RV64 bitmanip ISE: rori, orn, andn.
- Accepts encoded instruction words with operand values and decodes them.
- Drives the combinational ISE datapath (rs1, rs2, imm, one-hot op selects) from a registered stage, then captures the datapath result for writeback.
- Sits between the core's operand-read stage and the register-file writeback port.

---
 rtl/rv64_ise_issue.sv | 168 ++++++++++++++++
 tb/tb_rv64_ise_issue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv64_ise_issue.sv
// Issue/writeback pipeline for the Ascon RV64 bitmanip ISE (rori, orn, andn).
// Optional performance counters are enabled by defining RV64_ISE_ISSUE_PERF_EN.
module rv64_ise_issue #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic [XLEN-1:0] ise_rs1,
  output logic [XLEN-1:0] ise_rs2,
  output logic [4:0]      ise_imm,
  output logic            ise_op_rori,
  output logic            ise_op_iorn,
  output logic            ise_op_andn,
  input  logic [XLEN-1:0] ise_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RD_W-1:0] out_rd_addr,
  output logic [XLEN-1:0] out_result,
  output logic            out_trap
`ifdef RV64_ISE_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_retired,
  output logic [31:0]     perf_stall
`endif
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_dec_rori;
  logic       w_dec_orn;
  logic       w_dec_andn;
  logic       w_dec_ill;
  logic       w_unused_rs1f;

  logic       w_x2w_ok;
  logic       w_acc;
  logic       w_x2w;

  logic            r_vld_p1;
  logic            r_rori_p1;
  logic            r_orn_p1;
  logic            r_andn_p1;
  logic            r_ill_p1;
  logic [XLEN-1:0] r_rs1_p1;
  logic [XLEN-1:0] r_rs2_p1;
  logic [4:0]      r_imm_p1;
  logic [RD_W-1:0] r_rd_p1;

  logic            r_vld_p2;
  logic            r_trap_p2;
  logic [RD_W-1:0] r_rd_p2;
  logic [XLEN-1:0] r_res_p2;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign w_unused_rs1f = ^in_instr[19:15];

  // rori needs instr[25]=0: the datapath rotates by 0..31 only.
  assign w_dec_rori = (w_opcode == 7'b0010011) && (w_funct3 == 3'b101) &&
                      (w_funct7 == 7'b0110000);
  assign w_dec_orn  = (w_opcode == 7'b0110011) && (w_funct3 == 3'b110) &&
                      (w_funct7 == 7'b0100000);
  assign w_dec_andn = (w_opcode == 7'b0110011) && (w_funct3 == 3'b111) &&
                      (w_funct7 == 7'b0100000);
  assign w_dec_ill  = !(w_dec_rori || w_dec_orn || w_dec_andn);

  assign w_x2w_ok = !r_vld_p2 || out_ready;
  assign in_ready = !r_vld_p1 || w_x2w_ok;
  assign w_acc    = in_valid && in_ready;
  assign w_x2w    = r_vld_p1 && w_x2w_ok;

  // Stage X: decoded op and operands, driven straight into the datapath
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_vld_p1  <= 1'b0;
      r_rori_p1 <= 1'b0;
      r_orn_p1  <= 1'b0;
      r_andn_p1 <= 1'b0;
      r_ill_p1  <= 1'b0;
      r_rs1_p1  <= '0;
      r_rs2_p1  <= '0;
      r_imm_p1  <= '0;
      r_rd_p1   <= '0;
    end else begin
      if (flush) begin
        r_vld_p1 <= 1'b0;
      end else if (in_ready) begin
        r_vld_p1 <= in_valid;
      end
      if (w_acc && !flush) begin
        r_rori_p1 <= w_dec_rori;
        r_orn_p1  <= w_dec_orn;
        r_andn_p1 <= w_dec_andn;
        r_ill_p1  <= w_dec_ill;
        r_rs1_p1  <= in_rs1;
        r_rs2_p1  <= in_rs2;
        r_imm_p1  <= in_instr[24:20];
        r_rd_p1   <= in_instr[7 +: RD_W];
      end
    end
  end

  assign ise_rs1     = r_rs1_p1;
  assign ise_rs2     = r_rs2_p1;
  assign ise_imm     = r_imm_p1;
  assign ise_op_rori = r_rori_p1;
  assign ise_op_iorn = r_orn_p1;
  assign ise_op_andn = r_andn_p1;

  // Stage W: captured datapath result awaiting the register-file port
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_vld_p2  <= 1'b0;
      r_trap_p2 <= 1'b0;
      r_rd_p2   <= '0;
      r_res_p2  <= '0;
    end else begin
      if (flush) begin
        r_vld_p2 <= 1'b0;
      end else if (w_x2w_ok) begin
        r_vld_p2 <= r_vld_p1;
      end
      if (w_x2w && !flush) begin
        r_trap_p2 <= r_ill_p1;
        r_rd_p2   <= r_rd_p1;
        r_res_p2  <= r_ill_p1 ? '0 : ise_rd;
      end
    end
  end

  assign out_valid   = r_vld_p2;
  assign out_trap    = r_trap_p2;
  assign out_rd_addr = r_rd_p2;
  assign out_result  = r_res_p2;

`ifdef RV64_ISE_ISSUE_PERF_EN
  logic [31:0] r_perf_retired;
  logic [31:0] r_perf_stall;

  // Counters survive flush; they wrap naturally at 2^32.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_perf_retired <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (out_valid && out_ready && !out_trap) begin
        r_perf_retired <= r_perf_retired + 32'd1;
      end
      if (in_valid && !in_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_retired = r_perf_retired;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_rv64_ise_issue.sv
// Bench for rv64_ise_issue: directed scenarios plus random traffic, checked
// against an in-order queue model of the issue/writeback pipeline.
module tb_rv64_ise_issue;

  logic        clk = 1'b0;
  logic        g_resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [63:0] ise_rs1;
  logic [63:0] ise_rs2;
  logic [4:0]  ise_imm;
  logic        ise_op_rori;
  logic        ise_op_iorn;
  logic        ise_op_andn;
  logic [63:0] ise_rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd_addr;
  logic [63:0] out_result;
  logic        out_trap;

  always #5 clk = ~clk;

  rv64_ise_issue #(.XLEN(64), .RD_W(5)) dut (
    .g_clk       (clk),
    .g_resetn    (g_resetn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .ise_rs1     (ise_rs1),
    .ise_rs2     (ise_rs2),
    .ise_imm     (ise_imm),
    .ise_op_rori (ise_op_rori),
    .ise_op_iorn (ise_op_iorn),
    .ise_op_andn (ise_op_andn),
    .ise_rd      (ise_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd_addr (out_rd_addr),
    .out_result  (out_result),
    .out_trap    (out_trap)
  );

  // Combinational ISE datapath stand-in
  logic [127:0] dp_dbl;
  always_comb begin
    dp_dbl = {ise_rs1, ise_rs1} >> ise_imm;
    ise_rd = 64'd0;
    if (ise_op_rori)      ise_rd = dp_dbl[63:0];
    else if (ise_op_iorn) ise_rd = ise_rs1 | ~ise_rs2;
    else if (ise_op_andn) ise_rd = ise_rs1 & ~ise_rs2;
  end

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] res;
    logic        trap;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  imm;
    logic [2:0]  ops;
    bit          in_w;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t make_ent(input bit [31:0] w, input bit [63:0] a, input bit [63:0] b);
    ent_t e;
    int   sh;
    e.rd   = w[11:7];
    e.imm  = w[24:20];
    e.a    = a;
    e.b    = b;
    e.in_w = 1'b0;
    e.ops  = 3'b000;
    e.res  = 64'd0;
    e.trap = 1'b0;
    sh = int'(w[24:20]);
    if (w[6:0] == 7'h13 && w[14:12] == 3'd5 && w[31:25] == 7'b0110000) begin
      e.ops = 3'b100;
      e.res = (a >> sh) | (a << (64 - sh));
    end else if (w[6:0] == 7'h33 && w[31:25] == 7'h20 && w[14:12] == 3'd6) begin
      e.ops = 3'b010;
      e.res = a | ~b;
    end else if (w[6:0] == 7'h33 && w[31:25] == 7'h20 && w[14:12] == 3'd7) begin
      e.ops = 3'b001;
      e.res = a & ~b;
    end else begin
      e.trap = 1'b1;
    end
    return e;
  endfunction

  function automatic bit [31:0] rand_instr();
    bit [4:0] f1, f2, f3;
    bit [31:0] w;
    f1 = 5'($urandom);
    f2 = 5'($urandom);
    f3 = 5'($urandom);
    case ($urandom_range(0, 5))
      0:       w = {7'b0110000, f1, f2, 3'b101, f3, 7'h13};
      1:       w = {7'b0110001, f1, f2, 3'b101, f3, 7'h13};
      2:       w = {7'b0100000, f1, f2, 3'b110, f3, 7'h33};
      3:       w = {7'b0100000, f1, f2, 3'b111, f3, 7'h33};
      4:       w = 32'h00000013;
      default: w = $urandom();
    endcase
    return w;
  endfunction

  function automatic bit [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic step(input bit iv, input bit [31:0] ins, input bit [63:0] a,
                      input bit [63:0] b, input bit ordy, input bit fl);
    bit head_w, exp_rdy, acc;
    int xi;
    @(negedge clk);
    in_valid  = iv;
    in_instr  = ins;
    in_rs1    = a;
    in_rs2    = b;
    out_ready = ordy;
    flush     = fl;
    #1;
    head_w  = (q.size() > 0) && q[0].in_w;
    exp_rdy = (q.size() < 2) || ordy;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(head_w));
    if (head_w) begin
      chk("out_rd_addr", 64'(out_rd_addr), 64'(q[0].rd));
      chk("out_result", out_result, q[0].res);
      chk("out_trap", 64'(out_trap), 64'(q[0].trap));
    end
    xi = -1;
    for (int i = 0; i < q.size(); i++) if (!q[i].in_w && xi < 0) xi = i;
    if (xi >= 0) begin
      chk("ise_rs1", ise_rs1, q[xi].a);
      chk("ise_rs2", ise_rs2, q[xi].b);
      chk("ise_imm", 64'(ise_imm), 64'(q[xi].imm));
      chk("ise_ops", 64'({ise_op_rori, ise_op_iorn, ise_op_andn}), 64'(q[xi].ops));
    end
    acc = iv && exp_rdy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (head_w && ordy) void'(q.pop_front());
      if ((!head_w || ordy) && q.size() > 0 && !q[0].in_w) q[0].in_w = 1'b1;
      if (acc) q.push_back(make_ent(ins, a, b));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ise_ops", 64'({ise_op_rori, ise_op_iorn, ise_op_andn}), 64'd0);
    chk("rst_ise_rs1", ise_rs1, 64'd0);
    chk("rst_ise_rs2", ise_rs2, 64'd0);
    chk("rst_ise_imm", 64'(ise_imm), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_rd_addr", 64'(out_rd_addr), 64'd0);
    chk("rst_out_trap", 64'(out_trap), 64'd0);
  endtask

  localparam bit [31:0] RORI15  = 32'h60F0D093;
  localparam bit [31:0] RORI_BAD = 32'h62F0D093;
  localparam bit [31:0] ANDN    = {7'h20, 5'd2, 5'd1, 3'b111, 5'd3, 7'h33};
  localparam bit [31:0] ORN     = {7'h20, 5'd2, 5'd1, 3'b110, 5'd4, 7'h33};
  localparam bit [63:0] OPA     = 64'hFFFF0000FFFF0000;
  localparam bit [63:0] OPB     = 64'h0F0F0F0F0F0F0F0F;

  initial begin
    g_resetn  = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_rs1    = 64'd0;
    in_rs2    = 64'd0;
    out_ready = 1'b1;
    #2;
    check_reset_vals();
    @(negedge clk);
    g_resetn = 1'b1;

    // rori by 15 with latency 2
    step(1'b1, RORI15, 64'h0123456789ABCDEF, 64'd0, 1'b1, 1'b0);
    idle(3);

    // andn then orn back to back at full throughput
    step(1'b1, ANDN, OPA, OPB, 1'b1, 1'b0);
    step(1'b1, ORN, OPA, OPB, 1'b1, 1'b0);
    idle(1);
    chk("andn_result_const", out_result, 64'hF0F00000F0F00000);
    idle(2);

    // illegal encodings trap with zero result
    step(1'b1, RORI_BAD, rand64(), rand64(), 1'b1, 1'b0);
    step(1'b1, 32'h00000013, rand64(), rand64(), 1'b1, 1'b0);
    idle(3);

    // backpressure: 3 offered, 2 held, release drains in order
    step(1'b1, ANDN, 64'h1111, 64'h0101, 1'b0, 1'b0);
    step(1'b1, ORN, 64'h2222, 64'h0202, 1'b0, 1'b0);
    step(1'b1, RORI15, 64'h3333, 64'h0303, 1'b0, 1'b0);
    step(1'b1, RORI15, 64'h3333, 64'h0303, 1'b0, 1'b0);
    step(1'b1, RORI15, 64'h3333, 64'h0303, 1'b0, 1'b0);
    step(1'b1, RORI15, 64'h3333, 64'h0303, 1'b1, 1'b0);
    idle(4);

    // flush with X and W occupied and a same-cycle offer
    step(1'b1, ANDN, rand64(), rand64(), 1'b0, 1'b0);
    step(1'b1, ORN, rand64(), rand64(), 1'b0, 1'b0);
    step(1'b1, RORI15, rand64(), rand64(), 1'b0, 1'b1);
    idle(4);

    // asynchronous reset mid-stream
    step(1'b1, ANDN, rand64(), rand64(), 1'b0, 1'b0);
    step(1'b1, ORN, rand64(), rand64(), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    g_resetn = 1'b0;
    #1;
    check_reset_vals();
    q.delete();
    @(negedge clk);
    g_resetn = 1'b1;
    step(1'b1, RORI15, rand64(), 64'd0, 1'b1, 1'b0);
    idle(3);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), rand_instr(), rand64(), rand64(),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
